data_lsu: RTL
=============

// Module: data_lsu
// PURPOSE
//  Load/store unit between core execute stage and data RAM (word-only, no byte enables,
//  combinational read, window 0x6800_0000..0x6800_03FC). Converts LB/LH/LW/LBU/LHU/SB/SH/SW
//  into word accesses; sub-word stores done as read-modify-write. Stalls core via lsu_stall_o.
// PARAMETERS
//  AW   32  address width, core and memory side
//  DW   32  data width; fixed at 32 (byte lanes assume 4)
// PORTS
//  CLK           in   1   clock, rising edge
//  RSTn          in   1   asynchronous active-low reset
//  lsu_req_i     in   1   core memory request, held stable while lsu_stall_o=1
//  lsu_we_i      in   1   1=store, 0=load
//  lsu_size_i    in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  lsu_addr_i    in   AW  byte address
//  lsu_wdata_i   in   DW  store data (low bits used for B/H)
//  lsu_rdata_o   out  DW  load result, registered, aligned and extended
//  lsu_stall_o   out  1   core must hold request/PC
//  lsu_misalign_o out 1   misaligned access flag (only with LSU_MISALIGN_TRAP_EN)
//  mem_we_o      out  1   data RAM write enable
//  mem_addr_o    out  AW  data RAM address, lsu_addr_i with [1:0]=00
//  mem_wd_o      out  DW  data RAM write data (full word)
//  mem_rd_i      in   DW  data RAM read data, combinational from mem_addr_o
// BEHAVIOUR
//  Reset: state=IDLE; lsu_rdata_o=0, lsu_stall_o=0, mem_we_o=0, lsu_misalign_o=0, rmw_q=0.
//  FSM: IDLE, LOAD_RSP, STORE_WR. mem_addr_o always from lsu_addr_i (core holds it).
//  IDLE, no req: stall=0, we=0, no state change.
//  IDLE, req load: stall=1; capture extend(mem_rd_i) into lsu_rdata_o; -> LOAD_RSP.
//  LOAD_RSP: stall=0, lsu_rdata_o valid this cycle and held until next load; -> IDLE.
//  IDLE, req SW: mem_we_o=1, mem_wd_o=lsu_wdata_i same cycle, stall=0; stay IDLE (1 cycle).
//  IDLE, req SB/SH: stall=1, capture mem_rd_i into rmw_q, we=0; -> STORE_WR.
//  STORE_WR: mem_we_o=1, mem_wd_o=rmw_q with addressed lane(s) replaced; stall=0; -> IDLE.
//  Latency: load 2 cycles, SW 1 cycle, SB/SH 2 cycles; next request accepted in IDLE only.
//  Lanes: byte lane = addr[1:0]; half lane = addr[1] (addr[0] ignored); W ignores addr[1:0].
//  Extension: B/H sign-extend bit 7/15 of selected lane; BU/HU zero-extend.
//  Illegal size (011, 110, 111): no write, load returns 0, stall=0, stay IDLE.
//  Out-of-window address: passed through; RAM returns 0, so loads yield 0 (no error).
//  RSTn low mid-operation: immediate return to IDLE, mem_we_o=0, pending store dropped.
//  mem_we_o never asserted while RSTn low or in LOAD_RSP.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 -> no RAM
//   access, lsu_misalign_o=1 for that cycle, stall=0, lsu_rdata_o unchanged, stay IDLE.
//  Undefined: lsu_misalign_o tied 0; low bits silently truncated as per lane rules above.
// STRUCTURE
//  lsu_pkg: size-code localparams (LSU_B..LSU_HU), typedef enum lsu_state_t {IDLE,
//   LOAD_RSP, STORE_WR}, function be_from_size(size, addr[1:0]) -> 4-bit lane mask.
//  Sub-module lsu_extend: combinational lane select + sign/zero extension for loads.
//  Top: FSM, rmw_q register, store merge via lane mask.
// TESTING
//  SW 0xDEADBEEF @0x6800_0010, then LW same -> 1-cycle write, load stall 1 cycle, rdata 0xDEADBEEF.
//  Word 0x11223344 @0x6800_0020; SB 0xAA @+2 -> stall 1 cycle, RAM word 0x11AA3344.
//  Word 0x8000_80F0 @0x6800_0030: LB @+0 -> 0xFFFF_FFF0; LBU -> 0x0000_00F0; LH @+2 -> 0xFFFF_8000.
//  LW @0x7000_0000 -> rdata 0x0; SW @0x6800_0400 with size 011 -> no mem_we_o pulse.
//  Assert RSTn low in STORE_WR -> no write, outputs at reset values, RAM word unchanged.
//  LH @0x6800_0001: with LSU_MISALIGN_TRAP_EN lsu_misalign_o=1, no access; without, reads half 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data load/store unit: size codes, FSM states,
// byte-lane mask and misalignment predicates.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_RSP = 2'd1,
    STORE_WR = 2'd2
  } lsu_state_t;

  function automatic logic size_legal(input logic [2:0] size);
    logic ok;
    case (size)
      LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Half-word lanes ignore addr[0]; words ignore addr[1:0].
  function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      LSU_B, LSU_BU: be = 4'b0001 << addr;
      LSU_H, LSU_HU: be = addr[1] ? 4'b1100 : 4'b0011;
      LSU_W:         be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
    logic mis;
    case (size)
      LSU_H, LSU_HU: mis = addr[0];
      LSU_W:         mis = (addr != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data path: selects the addressed byte/half lane of a RAM word and
// sign- or zero-extends it to 32 bits.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (addr_lo)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size)
      LSU_B:   data = {{24{byte_s[7]}}, byte_s};
      LSU_BU:  data = {24'h00_0000, byte_s};
      LSU_H:   data = {{16{half_s[15]}}, half_s};
      LSU_HU:  data = {16'h0000, half_s};
      LSU_W:   data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit between the execute stage and a word-only data RAM; sub-word
// stores are read-modify-write. Optional feature macro: LSU_MISALIGN_TRAP_EN.
module data_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          lsu_req_i,
  input  logic          lsu_we_i,
  input  logic [2:0]    lsu_size_i,
  input  logic [AW-1:0] lsu_addr_i,
  input  logic [DW-1:0] lsu_wdata_i,
  output logic [DW-1:0] lsu_rdata_o,
  output logic          lsu_stall_o,
  output logic          lsu_misalign_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wd_o,
  input  logic [DW-1:0] mem_rd_i
);

  lsu_state_t  state_r;
  lsu_state_t  state_nxt_s;
  logic [31:0] rdata_r;
  logic [31:0] rmw_r;
  logic [31:0] ext_s;
  logic [31:0] wrep_s;
  logic [31:0] merge_s;
  logic [31:0] wd_s;
  logic [3:0]  lane_s;
  logic        legal_s;
  logic        mis_s;
  logic        stall_s;
  logic        we_s;
  logic        cap_load_s;
  logic        clr_rdata_s;
  logic        cap_rmw_s;

  assign legal_s = size_legal(lsu_size_i);
  assign lane_s  = be_from_size(lsu_size_i, lsu_addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_s = legal_s & is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  lsu_extend u_extend (
    .size    (lsu_size_i),
    .addr_lo (lsu_addr_i[1:0]),
    .word    (mem_rd_i),
    .data    (ext_s)
  );

  // Store data replicated across lanes, then merged into the captured RAM word
  always_comb begin
    wrep_s  = lsu_wdata_i;
    merge_s = rmw_r;
    case (lsu_size_i)
      LSU_B, LSU_BU: wrep_s = {4{lsu_wdata_i[7:0]}};
      LSU_H, LSU_HU: wrep_s = {2{lsu_wdata_i[15:0]}};
      default:       wrep_s = lsu_wdata_i;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (lane_s[i]) begin
        merge_s[8*i +: 8] = wrep_s[8*i +: 8];
      end else begin
        merge_s[8*i +: 8] = rmw_r[8*i +: 8];
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    we_s        = 1'b0;
    wd_s        = lsu_wdata_i;
    cap_load_s  = 1'b0;
    clr_rdata_s = 1'b0;
    cap_rmw_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!lsu_req_i) begin
          state_nxt_s = IDLE;
        end else if (!legal_s) begin
          // Illegal size: nothing touches RAM; a load reports zero
          clr_rdata_s = ~lsu_we_i;
        end else if (mis_s) begin
          state_nxt_s = IDLE;
        end else if (!lsu_we_i) begin
          stall_s     = 1'b1;
          cap_load_s  = 1'b1;
          state_nxt_s = LOAD_RSP;
        end else if (lsu_size_i == LSU_W) begin
          we_s = 1'b1;
        end else begin
          stall_s     = 1'b1;
          cap_rmw_s   = 1'b1;
          state_nxt_s = STORE_WR;
        end
      end
      LOAD_RSP: begin
        state_nxt_s = IDLE;
      end
      STORE_WR: begin
        we_s        = 1'b1;
        wd_s        = merge_s;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, load result and read-modify-write capture registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= IDLE;
      rdata_r <= 32'h0000_0000;
      rmw_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (cap_load_s) begin
        rdata_r <= ext_s;
      end else if (clr_rdata_s) begin
        rdata_r <= 32'h0000_0000;
      end else begin
        rdata_r <= rdata_r;
      end
      if (cap_rmw_s) begin
        rmw_r <= mem_rd_i;
      end else begin
        rmw_r <= rmw_r;
      end
    end
  end

  // Control outputs are gated by RSTn so a reset mid-store can never write
  assign lsu_rdata_o    = rdata_r;
  assign lsu_stall_o    = stall_s & RSTn;
  assign mem_we_o       = we_s & RSTn;
  assign lsu_misalign_o = mis_s & lsu_req_i & (state_r == IDLE) & RSTn;
  assign mem_addr_o     = {lsu_addr_i[AW-1:2], 2'b00};
  assign mem_wd_o       = wd_s;

endmodule
